instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of the instruction-memory word address.
REQ-002 Parameter BASE_ADDR, default 0: first word address written after reset or clear.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous restart: flush, address back to BASE_ADDR.
REQ-006 in_valid  input  1  an instruction request is present.
REQ-007 in_ready  output  1  the encoder accepts a request this cycle.
REQ-008 in_op  input  4  mnemonic code: 0 R_TYPE, 1 ADDI, 2 ORI, 3 LUI, 4 BEQ, 5 BNE, 6 ANDI, 7 LW, 8 SW; 9-15 illegal.
REQ-009 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-010 in_funct  input  6  R-type function field.
REQ-011 in_imm  input  16  I-type immediate.
REQ-012 wr_en  output  1  instruction-memory write request.
REQ-013 wr_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-014 wr_data  output  32  encoded instruction word.
REQ-015 wr_ready  input  1  memory accepts the write this cycle.
REQ-016 illegal  output  1  sticky flag: an illegal mnemonic was consumed.
REQ-017 instr_count  output  ADDR_WIDTH+1  number of completed writes.
REQ-018 mem_full  output  1  every address from BASE_ADDR to 2^ADDR_WIDTH-1 has been written.

Function
REQ-019 An input transfer SHALL occur when in_valid and in_ready are both high at a clock edge.
REQ-020 R_TYPE SHALL encode as {6'h00, rs, rt, rd, shamt, funct}.
REQ-021 Each I-type SHALL encode as {opcode, rs, rt, imm}, with opcodes ADDI 0x08, ORI 0x0D, LUI 0x0F, BEQ 0x04, BNE 0x05, ANDI 0x0C, LW 0x23, SW 0x2B.
REQ-022 LUI SHALL force the rs field to 0; fields unused by the mnemonic (rd, shamt, funct for I-type) SHALL be ignored.
REQ-023 An accepted word SHALL enter a 2-entry FIFO in order; an illegal mnemonic SHALL be consumed without a FIFO entry and SHALL set illegal on the next edge.
REQ-024 in_ready SHALL equal: !clear AND FIFO not full AND (instr_count + FIFO occupancy) < 2^ADDR_WIDTH - BASE_ADDR. No accepted word is ever dropped.
REQ-025 wr_en SHALL be high whenever the FIFO is non-empty and the state is RUN; wr_addr and wr_data SHALL show the FIFO head.
REQ-026 wr_en, wr_addr and wr_data SHALL hold stable until a write completes (wr_en AND wr_ready).
REQ-027 On a write completion, the FIFO SHALL pop, wr_addr SHALL increment by 1 and instr_count SHALL increment by 1.
REQ-028 Latency: a word accepted into an empty FIFO at edge N SHALL drive wr_en from cycle N+1.
REQ-029 With wr_ready held high, the block SHALL sustain one word per cycle; a push and a pop in the same cycle SHALL both take effect.
REQ-030 State machine: IDLE -> RUN on the first accepted legal word; RUN -> FULL when the write to address 2^ADDR_WIDTH-1 completes; FULL -> IDLE on clear.
REQ-031 clear in any state SHALL go to IDLE and SHALL flush the FIFO, abandoning any pending write.
REQ-032 clear SHALL also set wr_addr to BASE_ADDR and zero instr_count and illegal.
REQ-033 wr_addr SHALL never wrap; mem_full SHALL be 1 exactly in FULL.

Reset
REQ-034 reset SHALL asynchronously force IDLE, an empty FIFO, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, illegal=0, instr_count=0 and mem_full=0.
REQ-035 After reset, in_ready SHALL be 1, and reset asserted mid-write SHALL abandon the write immediately.

Structure
REQ-036 A shared package encoder_pkg SHALL hold the mnemonic codes, the MIPS opcode constants (shared with the control unit) and the state encoding.
REQ-037 The 2-entry FIFO SHALL be the sub-module encoder_fifo2; encoding logic stays in the top level.

Verification
REQ-038 ADDI rs=1 rt=2 imm=0x0005, wr_ready=1 -> next cycle wr_en=1, wr_addr=0, wr_data=0x20220005; instr_count=1 after the write.
REQ-039 R_TYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> wr_data=0x00221820; LUI rs=7 rt=1 imm=0x1001 -> wr_data=0x3C011001.
REQ-040 wr_ready=0 with 3 valid beats -> 2 accepted, then in_ready=0 and wr_data stable; release wr_ready -> writes to addresses 0 then 1 in order.
REQ-041 in_op=0xA -> consumed, no wr_en, illegal=1 next cycle, instr_count unchanged; clear -> illegal=0.
REQ-042 ADDR_WIDTH=2, 5 beats of LW rs=29 rt=8 imm=4 (0x8FA80004) -> 4 writes to addresses 0..3, 5th beat refused, mem_full=1, instr_count=4; clear -> IDLE, wr_addr=0.
REQ-043 reset asserted while wr_en=1 and wr_ready=0 -> all outputs take their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared encoder definitions: mnemonic codes, MIPS opcodes and FSM state encoding.
// The opcode constants are also consumed by the control unit.
package encoder_pkg;

  localparam logic [3:0] MN_R_TYPE = 4'd0;
  localparam logic [3:0] MN_ADDI   = 4'd1;
  localparam logic [3:0] MN_ORI    = 4'd2;
  localparam logic [3:0] MN_LUI    = 4'd3;
  localparam logic [3:0] MN_BEQ    = 4'd4;
  localparam logic [3:0] MN_BNE    = 4'd5;
  localparam logic [3:0] MN_ANDI   = 4'd6;
  localparam logic [3:0] MN_LW     = 4'd7;
  localparam logic [3:0] MN_SW     = 4'd8;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ADDI    = 6'h08;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_BNE     = 6'h05;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } encState_t;

endpackage

// File: rtl/encoder_fifo2.sv
// Two-entry in-order FIFO holding encoded words until the instruction memory takes them.
// Storage is reset so the head reads zero out of reset.
module encoder_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             rdPtr;
  logic             wrPtr;
  logic [1:0]       countQ;
  logic             doPush;
  logic             doPop;

  assign empty    = (countQ == 2'd0);
  assign full     = (countQ == 2'd2);
  assign count    = countQ;
  assign headData = mem[rdPtr];
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      countQ <= 2'd0;
    end else if (clear) begin
      rdPtr  <= 1'b0;
      wrPtr  <= 1'b0;
      countQ <= 2'd0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= ~wrPtr;
      end
      if (doPop) rdPtr <= ~rdPtr;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 2'd1;
        2'b01:   countQ <= countQ - 2'd1;
        default: countQ <= countQ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes mnemonic requests into MIPS words and streams them into instruction memory
// at consecutive addresses, stopping once the top address has been written.
//
//   state   | meaning
//   IDLE    | nothing accepted since reset/clear
//   RUN     | writing queued words to memory
//   FULL    | top address written; waits for clear
module instruction_encoder
  import encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  input  logic                  wr_ready,
  output logic                  illegal,
  output logic [ADDR_WIDTH:0]   instr_count,
  output logic                  mem_full
);

  localparam logic [ADDR_WIDTH+1:0] CAPACITY  = (ADDR_WIDTH+2)'((2 ** ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  encState_t             state;
  logic [ADDR_WIDTH-1:0] wrAddrQ;
  logic [ADDR_WIDTH:0]   instrCountQ;
  logic                  illegalQ;
  logic [5:0]            opcode;
  logic                  opLegal;
  logic [31:0]           encWord;
  logic                  accept;
  logic                  pushLegal;
  logic                  writeDone;
  logic [31:0]           fifoHead;
  logic [1:0]            fifoCount;
  logic                  fifoEmpty;
  logic                  fifoFull;
  logic [ADDR_WIDTH+1:0] committed;

  always_comb begin
    opcode  = OPC_SPECIAL;
    opLegal = 1'b1;
    case (in_op)
      MN_R_TYPE: opcode = OPC_SPECIAL;
      MN_ADDI:   opcode = OPC_ADDI;
      MN_ORI:    opcode = OPC_ORI;
      MN_LUI:    opcode = OPC_LUI;
      MN_BEQ:    opcode = OPC_BEQ;
      MN_BNE:    opcode = OPC_BNE;
      MN_ANDI:   opcode = OPC_ANDI;
      MN_LW:     opcode = OPC_LW;
      MN_SW:     opcode = OPC_SW;
      default:   opLegal = 1'b0;
    endcase
    if (in_op == MN_R_TYPE)
      encWord = {opcode, in_rs, in_rt, in_rd, in_shamt, in_funct};
    else
      encWord = {opcode, (in_op == MN_LUI) ? 5'd0 : in_rs, in_rt, in_imm};
  end

  // Words already written plus words queued must never exceed the address space left.
  assign committed = {1'b0, instrCountQ} + (ADDR_WIDTH+2)'(fifoCount);
  assign in_ready  = !clear && !fifoFull && (committed < CAPACITY);
  assign accept    = in_valid && in_ready;
  assign pushLegal = accept && opLegal;
  assign writeDone = wr_en && wr_ready;

  encoder_fifo2 #(.WIDTH(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (pushLegal),
    .pushData (encWord),
    .pop      (writeDone),
    .headData (fifoHead),
    .count    (fifoCount),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wrAddrQ     <= BASE;
      instrCountQ <= '0;
      illegalQ    <= 1'b0;
    end else if (clear) begin
      state       <= ST_IDLE;
      wrAddrQ     <= BASE;
      instrCountQ <= '0;
      illegalQ    <= 1'b0;
    end else begin
      if (accept && !opLegal) illegalQ <= 1'b1;
      if (writeDone) instrCountQ <= instrCountQ + (ADDR_WIDTH+1)'(1);
      case (state)
        ST_IDLE: if (pushLegal) state <= ST_RUN;
        ST_RUN: begin
          // The address holds at the top rather than wrapping back to zero.
          if (writeDone) begin
            if (wrAddrQ == LAST_ADDR) state <= ST_FULL;
            else wrAddrQ <= wrAddrQ + ADDR_WIDTH'(1);
          end
        end
        ST_FULL: state <= ST_FULL;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en       = (state == ST_RUN) && !fifoEmpty;
  assign wr_addr     = wrAddrQ;
  assign wr_data     = fifoHead;
  assign illegal     = illegalQ;
  assign instr_count = instrCountQ;
  assign mem_full    = (state == ST_FULL);

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder on a 4-word memory: a scoreboard predicts every write,
// directed checks pin the literal encodings, backpressure, fill-up, clear and reset.
module tb_instruction_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, clear, in_valid, in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic          wr_en, wr_ready, illegal, mem_full;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   instr_count;

  always #5 clk = ~clk;

  instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ready(wr_ready), .illegal(illegal),
    .instr_count(instr_count), .mem_full(mem_full)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelEncode(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm);
    logic [5:0] opc;
    case (op)
      4'd1:    opc = 6'h08;
      4'd2:    opc = 6'h0D;
      4'd3:    opc = 6'h0F;
      4'd4:    opc = 6'h04;
      4'd5:    opc = 6'h05;
      4'd6:    opc = 6'h0C;
      4'd7:    opc = 6'h23;
      4'd8:    opc = 6'h2B;
      default: opc = 6'h00;
    endcase
    if (op == 4'd0) return {6'h00, rs, rt, rd, sh, fn};
    if (op == 4'd3) return {opc, 5'd0, rt, imm};
    return {opc, rs, rt, imm};
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wrExp_t;

  wrExp_t        expQ[$];
  int            mCount;
  bit            mRunning, mFull, mIllegal;
  logic [AW-1:0] mPushAddr;

  task automatic modelReset();
    expQ.delete();
    mCount    = 0;
    mRunning  = 0;
    mFull     = 0;
    mIllegal  = 0;
    mPushAddr = '0;
  endtask

  function automatic bit expReady();
    return !clear && (expQ.size() < 2) && ((mCount + expQ.size()) < DEPTH);
  endfunction

  // Monitor: compare outputs at mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    wrExp_t e;
    if (reset) modelReset();
    else begin
      checkValue("inReady", 32'(in_ready), 32'(expReady()));
      checkValue("wrEn", 32'(wr_en), 32'(mRunning && !mFull && (expQ.size() > 0)));
      checkValue("illegal", 32'(illegal), 32'(mIllegal));
      checkValue("instrCount", 32'(instr_count), 32'(mCount));
      checkValue("memFull", 32'(mem_full), 32'(mFull));
      if (wr_en && expQ.size() > 0) begin
        checkValue("wrAddr", 32'(wr_addr), 32'(expQ[0].addr));
        checkValue("wrData", wr_data, expQ[0].data);
      end
      if (clear) modelReset();
      else begin
        if (wr_en && wr_ready && expQ.size() > 0) begin
          void'(expQ.pop_front());
          mCount++;
          if (mCount == DEPTH) mFull = 1;
        end
        if (in_valid && in_ready) begin
          if (in_op <= 4'd8) begin
            e.addr = mPushAddr;
            e.data = modelEncode(in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm);
            expQ.push_back(e);
            mPushAddr = mPushAddr + AW'(1);
            mRunning  = 1;
          end else mIllegal = 1;
        end
      end
    end
  end

  task automatic sendBeat(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input int maxWait, output bit taken);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm;
    taken = 0;
    for (int i = 0; i < maxWait && !taken; i++) begin
      @(negedge clk);
      if (in_ready) taken = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (expQ.size() != 0 && n < maxCycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkValue("drainDone", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetValues(input string pfx);
    checkValue({pfx, "WrEn"}, 32'(wr_en), 32'd0);
    checkValue({pfx, "WrAddr"}, 32'(wr_addr), 32'd0);
    checkValue({pfx, "WrData"}, wr_data, 32'd0);
    checkValue({pfx, "Illegal"}, 32'(illegal), 32'd0);
    checkValue({pfx, "Count"}, 32'(instr_count), 32'd0);
    checkValue({pfx, "MemFull"}, 32'(mem_full), 32'd0);
  endtask

  initial begin
    bit tk;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_funct = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("rst");
    checkValue("rstReady", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Single ADDI with the memory always ready
    wr_ready = 1'b1;
    sendBeat(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 4, tk);
    checkValue("addiTaken", 32'(tk), 32'd1);
    @(negedge clk);
    checkValue("addiWrEn", 32'(wr_en), 32'd1);
    checkValue("addiAddr", 32'(wr_addr), 32'd0);
    checkValue("addiData", wr_data, 32'h20220005);
    @(negedge clk);
    checkValue("addiCount", 32'(instr_count), 32'd1);
    @(posedge clk); #1;

    sendBeat(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hFFFF, 4, tk);
    @(negedge clk);
    checkValue("rtypeData", wr_data, 32'h00221820);
    checkValue("rtypeAddr", 32'(wr_addr), 32'd1);
    @(posedge clk); #1;
    sendBeat(4'd3, 5'd7, 5'd1, 5'd9, 5'd3, 6'h3F, 16'h1001, 4, tk);
    @(negedge clk);
    checkValue("luiData", wr_data, 32'h3C011001);
    checkValue("luiAddr", 32'(wr_addr), 32'd2);
    @(posedge clk); #1;
    doClear();
    checkValue("clrAddr", 32'(wr_addr), 32'd0);
    checkValue("clrCount", 32'(instr_count), 32'd0);

    // Backpressure: two words fill the FIFO, the third is refused
    wr_ready = 1'b0;
    sendBeat(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 1, tk);
    checkValue("bpTaken0", 32'(tk), 32'd1);
    sendBeat(4'd6, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h00FF, 1, tk);
    checkValue("bpTaken1", 32'(tk), 32'd1);
    sendBeat(4'd4, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0002, 1, tk);
    checkValue("bpTaken2", 32'(tk), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkValue("bpHoldData", wr_data, 32'hAC640010);
    checkValue("bpHoldAddr", 32'(wr_addr), 32'd0);
    checkValue("bpReady", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    waitDrain(10);
    @(negedge clk);
    checkValue("bpCount", 32'(instr_count), 32'd2);
    @(posedge clk); #1;

    // Illegal mnemonic is swallowed and flagged
    doClear();
    sendBeat(4'hA, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 4, tk);
    checkValue("illTaken", 32'(tk), 32'd1);
    @(negedge clk);
    checkValue("illFlag", 32'(illegal), 32'd1);
    checkValue("illWrEn", 32'(wr_en), 32'd0);
    checkValue("illCount", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    doClear();
    checkValue("illCleared", 32'(illegal), 32'd0);

    // ORI and BNE back to back
    sendBeat(4'd2, 5'd10, 5'd11, 5'd0, 5'd0, 6'd0, 16'hA5A5, 4, tk);
    sendBeat(4'd5, 5'd12, 5'd13, 5'd0, 5'd0, 6'd0, 16'hFFFE, 4, tk);
    waitDrain(10);
    doClear();

    // Fill all four addresses; fifth beat must be refused
    for (int i = 0; i < 5; i++) begin
      sendBeat(4'd7, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 3, tk);
      checkValue("fillTaken", 32'(tk), 32'(i < 4));
      if (i == 0) begin
        @(negedge clk);
        checkValue("lwData", wr_data, 32'h8FA80004);
        @(posedge clk); #1;
      end
    end
    waitDrain(10);
    @(negedge clk);
    checkValue("fullFlag", 32'(mem_full), 32'd1);
    checkValue("fullCount", 32'(instr_count), 32'd4);
    checkValue("fullAddr", 32'(wr_addr), 32'd3);
    checkValue("fullReady", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    doClear();
    checkValue("fullClrFlag", 32'(mem_full), 32'd0);
    checkValue("fullClrAddr", 32'(wr_addr), 32'd0);

    // Asynchronous reset in the middle of a stalled write
    sendBeat(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001, 3, tk);
    sendBeat(4'd1, 5'd2, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0002, 3, tk);
    wr_ready = 1'b0;
    sendBeat(4'd2, 5'd3, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0003, 3, tk);
    @(negedge clk);
    checkValue("preRstWrEn", 32'(wr_en), 32'd1);
    #1 reset = 1'b1;
    #1 checkResetValues("asyncRst");
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    checkValue("postRstReady", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
